// File: rtl/execute_hazard_controller.sv
// Execute-stage hazard scheduler: stall/flush control, operand bypass selects,
// data-memory wait handling and wrong-path squash after taken control flow.
module execute_hazard_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_BITS   = 5,
    parameter int CNT_BITS   = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_regwrite,
    input  logic                ex_memread,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic                mem_regwrite,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic                wb_regwrite,
    input  logic                ex_redirect,
    input  logic                mem_req,
    input  logic                mem_ready,
    output logic                stall,
    output logic                flush_id,
    output logic                flush_ex,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [1:0]          state,
    output logic [CNT_BITS-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_REDIRECT = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] stall_count_q, stall_count_d;

    logic       stall_c, flush_id_c, flush_ex_c;
    logic       load_use;
    logic       mem_wait_req;
    logic [REG_BITS-1:0] src_rs [2];
    logic [1:0]          fwd_sel [2];

    assign src_rs[0] = id_rs1;
    assign src_rs[1] = id_rs2;

    // Bypass select per ALU operand; MEM beats WB and x0 never forwards.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] =
                (mem_regwrite && (mem_rd != '0) && (mem_rd == src_rs[gi])) ? 2'b01 :
                (wb_regwrite  && (wb_rd  != '0) && (wb_rd  == src_rs[gi])) ? 2'b10 :
                                                                             2'b00;
        end
    endgenerate

    assign load_use = ex_memread && ex_regwrite && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign mem_wait_req = mem_req && !mem_ready;

    always_comb begin
        state_d    = state_q;
        stall_c    = 1'b0;
        flush_id_c = 1'b0;
        flush_ex_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_wait_req) begin
                    stall_c = 1'b1;
                    state_d = ST_MEM_WAIT;
                end else if (ex_redirect) begin
                    flush_id_c = 1'b1;
                    flush_ex_c = 1'b1;
                    state_d    = ST_REDIRECT;
                end else if (load_use) begin
                    stall_c    = 1'b1;
                    flush_ex_c = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // EX is frozen here, so redirect and load-use are not acted on.
                stall_c = !mem_ready;
                if (mem_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                // The synchronous IMEM still delivers one wrong-path fetch.
                flush_id_c = 1'b1;
                if (mem_wait_req) begin
                    stall_c = 1'b1;
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (!reset) begin
            stall_c    = 1'b0;
            flush_id_c = 1'b1;
            flush_ex_c = 1'b1;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_c && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall       = stall_c;
    assign flush_id    = flush_id_c;
    assign flush_ex    = flush_ex_c;
    assign fwd_a       = reset ? fwd_sel[0] : 2'b00;
    assign fwd_b       = reset ? fwd_sel[1] : 2'b00;
    assign state       = state_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_execute_hazard_controller.sv
// Table-driven bench for execute_hazard_controller with a scoreboard queue,
// plus a saturation sequence on a narrow-counter instance.
module tb_execute_hazard_controller;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_regwrite, ex_memread;
    logic       mem_regwrite, wb_regwrite, ex_redirect, mem_req, mem_ready;
    logic       stall, flush_id, flush_ex;
    logic [1:0] fwd_a, fwd_b, state;
    logic [15:0] stall_count;

    logic       s_reset, s_mem_req;
    logic [4:0] s_zero5;
    logic       s_zero;
    logic       s_stall, s_flush_id, s_flush_ex;
    logic [1:0] s_fwd_a, s_fwd_b, s_state;
    logic [3:0] s_stall_count;

    execute_hazard_controller #(.DATA_WIDTH(32), .REG_BITS(5), .CNT_BITS(16)) u_dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall(stall), .flush_id(flush_id), .flush_ex(flush_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .stall_count(stall_count)
    );

    execute_hazard_controller #(.DATA_WIDTH(32), .REG_BITS(5), .CNT_BITS(4)) u_sat (
        .clock(clock), .reset(s_reset),
        .id_rs1(s_zero5), .id_rs2(s_zero5),
        .id_uses_rs1(s_zero), .id_uses_rs2(s_zero),
        .ex_rd(s_zero5), .ex_regwrite(s_zero), .ex_memread(s_zero),
        .mem_rd(s_zero5), .mem_regwrite(s_zero),
        .wb_rd(s_zero5), .wb_regwrite(s_zero),
        .ex_redirect(s_zero), .mem_req(s_mem_req), .mem_ready(s_zero),
        .stall(s_stall), .flush_id(s_flush_id), .flush_ex(s_flush_ex),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .state(s_state), .stall_count(s_stall_count)
    );

    typedef struct {
        logic rst; logic [4:0] rs1, rs2; logic u1, u2;
        logic [4:0] exrd; logic exrw, exmr;
        logic [4:0] memrd; logic memrw;
        logic [4:0] wbrd; logic wbrw, redir, mreq, mrdy;
    } in_t;

    typedef struct {
        logic stall, fid, fex;
        logic [1:0] fa, fb, st;
        logic [15:0] cnt;
    } exp_t;

    typedef struct { in_t i; exp_t e; } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(
        input logic rst, input int rs1, input int rs2, input logic u1, input logic u2,
        input int exrd, input logic exrw, input logic exmr,
        input int memrd, input logic memrw, input int wbrd, input logic wbrw,
        input logic redir, input logic mreq, input logic mrdy,
        input logic e_stall, input logic e_fid, input logic e_fex,
        input int e_fa, input int e_fb, input int e_st, input int e_cnt);
        vec_t v;
        v.i.rst = rst; v.i.rs1 = 5'(rs1); v.i.rs2 = 5'(rs2); v.i.u1 = u1; v.i.u2 = u2;
        v.i.exrd = 5'(exrd); v.i.exrw = exrw; v.i.exmr = exmr;
        v.i.memrd = 5'(memrd); v.i.memrw = memrw; v.i.wbrd = 5'(wbrd); v.i.wbrw = wbrw;
        v.i.redir = redir; v.i.mreq = mreq; v.i.mrdy = mrdy;
        v.e.stall = e_stall; v.e.fid = e_fid; v.e.fex = e_fex;
        v.e.fa = 2'(e_fa); v.e.fb = 2'(e_fb); v.e.st = 2'(e_st); v.e.cnt = 16'(e_cnt);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic drive(input in_t i);
        reset = i.rst; id_rs1 = i.rs1; id_rs2 = i.rs2; id_uses_rs1 = i.u1; id_uses_rs2 = i.u2;
        ex_rd = i.exrd; ex_regwrite = i.exrw; ex_memread = i.exmr;
        mem_rd = i.memrd; mem_regwrite = i.memrw; wb_rd = i.wbrd; wb_regwrite = i.wbrw;
        ex_redirect = i.redir; mem_req = i.mreq; mem_ready = i.mrdy;
    endtask

    initial begin
        exp_t e;
        in_t  idle;
        //   rst rs1 rs2 u1 u2 exrd rw mr memrd rw wbrd rw rdr mrq mrd | stl fid fex fa fb st cnt
        add(0, 3, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0); // reset forces outputs
        add(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0); // load-use
        add(1, 5, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 1); // forwarded from MEM
        add(1, 0, 7, 0, 1, 0, 0, 0, 7, 1, 7, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1); // MEM beats WB
        add(1, 0, 7, 0, 1, 0, 0, 0, 7, 0, 7, 1, 0, 0, 0,   0, 0, 0, 0, 2, 0, 1); // WB only
        add(1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1); // x0 never forwards
        add(1, 3, 4, 1, 1, 0, 0, 0, 3, 1, 4, 1, 0, 0, 0,   0, 0, 0, 1, 2, 0, 1); // mixed sources
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 1); // mem wait entry
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 1, 3);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1, 4); // ready cycle
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 4);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0, 0, 4); // redirect
        add(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 2, 4); // load-use ignored
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 4);
        add(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 1, 1, 0,   1, 0, 0, 0, 0, 0, 4); // all three at once
        add(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 1, 1, 1,   0, 0, 0, 0, 0, 1, 5); // wait ignores others
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 5);
        add(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0, 0, 5); // redirect over load-use
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 2, 5); // REDIRECT -> MEM_WAIT
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 1, 6);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 1, 0, 0, 1, 7); // reset mid MEM_WAIT
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 2, 0); // reset mid REDIRECT
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(1, 9, 9, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0); // sources unused
        add(1, 0, 9, 0, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0); // load-use via rs2
        add(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1); // load to x0
        add(1, 6, 0, 1, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1); // load w/o regwrite

        idle = '{rst: 1'b0, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, exrd: 5'd0,
                 exrw: 1'b0, exmr: 1'b0, memrd: 5'd0, memrw: 1'b0, wbrd: 5'd0,
                 wbrw: 1'b0, redir: 1'b0, mreq: 1'b0, mrdy: 1'b0};
        drive(idle);
        s_reset = 1'b0; s_mem_req = 1'b0; s_zero5 = 5'd0; s_zero = 1'b0;
        @(posedge clock); #1;

        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n].i);
            sb.push_back(vecs[n].e);
            #4;
            e = sb.pop_front();
            chk($sformatf("v%0d stall", n),    16'(stall),    16'(e.stall));
            chk($sformatf("v%0d flush_id", n), 16'(flush_id), 16'(e.fid));
            chk($sformatf("v%0d flush_ex", n), 16'(flush_ex), 16'(e.fex));
            chk($sformatf("v%0d fwd_a", n),    16'(fwd_a),    16'(e.fa));
            chk($sformatf("v%0d fwd_b", n),    16'(fwd_b),    16'(e.fb));
            chk($sformatf("v%0d state", n),    16'(state),    16'(e.st));
            chk($sformatf("v%0d stall_count", n), stall_count, e.cnt);
            $display("vec %0d: stall=%0b fid=%0b fex=%0b fa=%0d fb=%0d st=%0d cnt=%0d",
                     n, stall, flush_id, flush_ex, fwd_a, fwd_b, state, stall_count);
            @(posedge clock); #1;
        end

        // 4-bit counter held in MEM_WAIT for 20 stall cycles must stop at 15.
        s_reset = 1'b1;
        s_mem_req = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            e.stall = 1'b1; e.fid = 1'b0; e.fex = 1'b0; e.fa = 2'b00; e.fb = 2'b00;
            e.st = (n == 0) ? 2'b00 : 2'b01;
            e.cnt = 16'((n > 15) ? 15 : n);
            sb.push_back(e);
            #4;
            e = sb.pop_front();
            chk($sformatf("sat%0d stall", n), 16'(s_stall), 16'(e.stall));
            chk($sformatf("sat%0d stall_count", n), 16'(s_stall_count), e.cnt);
            $display("sat %0d: stall=%0b cnt=%0d", n, s_stall, s_stall_count);
            @(posedge clock); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
